// File: rtl/ifetch_pkg.sv
// Shared CPU constants and the fetch-entry record used by the fetch front end.
package ifetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry synchronous FIFO of {pc, inst} records with flush; head is shown combinationally.
module ifetch_fifo2 import ifetch_pkg::*; (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, one-outstanding-request issue, bypass/FIFO return path and
// zero-bubble redirects. Optional address bounds check enabled by IFETCH_BOUNDS_CHECK_EN.
module ifetch_unit import ifetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   im_pc,
  input  logic [INST_W-1:0] im_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
`ifdef IFETCH_BOUNDS_CHECK_EN
  ,
  output logic              fault
`endif
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            fault_q, fault_d;

  logic [PC_W-1:0] cand_pc;
  logic            cand_bad;
  logic            credit_ok;
  logic            issue;
  logic            bypass;
  logic            pop;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    fifo_head;
  logic [1:0]      fifo_count;

  // Return path: bypass the in-flight word when the FIFO is empty, else present the head.
  always_comb begin
    cand_pc   = redirect_valid ? redirect_pc : fetch_pc_q;
    bypass    = (fifo_count == 2'd0);
    out_valid = rst_n & ~redirect_valid & (~bypass | inflight_q);
    out_pc    = '0;
    out_inst  = '0;
    if (rst_n) begin
      if (bypass) begin
        out_pc   = inflight_pc_q;
        out_inst = im_inst;
      end else begin
        out_pc   = fifo_head.pc;
        out_inst = fifo_head.inst;
      end
    end
    pop       = out_valid & out_ready;
    // A bypassed word taken this cycle never enters the FIFO.
    fifo_push = inflight_q & ~redirect_valid & ~(bypass & out_ready);
    fifo_pop  = pop & ~bypass;
    im_pc     = rst_n ? cand_pc : RESET_PC;
  end

`ifdef IFETCH_BOUNDS_CHECK_EN
  assign cand_bad = (cand_pc[1:0] != 2'b00) || (cand_pc > PC_W'(IM_BYTES - 4));
  assign fault    = rst_n & fault_q;
`else
  assign cand_bad = 1'b0;
`endif

  // Issue/credit: at most two words held or outstanding; a redirect frees all space.
  always_comb begin
    credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
    fault_d   = fault_q;
    if (redirect_valid) begin
      issue   = ~cand_bad;
      fault_d = cand_bad;
    end else begin
      issue = credit_ok & ~fault_q & ~cand_bad;
      if (credit_ok & cand_bad) begin
        fault_d = 1'b1;
      end
    end
    fetch_pc_d    = issue ? cand_pc + PC_STEP : cand_pc;
    inflight_d    = issue;
    inflight_pc_d = issue ? cand_pc : inflight_pc_q;
  end

  // PC, in-flight tracking and sticky fault, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
    end
  end

  ifetch_fifo2 u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i ('{pc: inflight_pc_q, inst: im_inst}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: fixed cycle table, randomized stream against an in-order PC model,
// and a bounds-check sequence when IFETCH_BOUNDS_CHECK_EN is defined.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_pc;
  logic [31:0] im_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef IFETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] mem [4096];

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .IM_BYTES (4096)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_pc          (im_pc),
    .im_inst        (im_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef IFETCH_BOUNDS_CHECK_EN
    ,
    .fault          (fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    return {mem[i], mem[i + 12'd1], mem[i + 12'd2], mem[i + 12'd3]};
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) im_inst <= mem_word(im_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eim;
  } vec_t;

  vec_t tbl [26];

  logic        first;
  logic [31:0] exp_pc;
  logic        r, rv, rdy, ev;
  logic [31:0] rpc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h0A; mem[1] = 8'h0A; mem[2] = 8'h2A; mem[3] = 8'h0A;

    //         rst   rv    rpc    rdy   ev    epc    eim
    tbl[0]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd4};
    tbl[3]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 32'd8};
    tbl[4]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd12};
    tbl[5]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd16};
    tbl[6]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd16};
    tbl[7]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd16};
    tbl[8]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd16};
    tbl[9]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 32'd16};
    tbl[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd12, 32'd20};
    tbl[11] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd16, 32'd24};
    tbl[12] = '{1'b1, 1'b1, 32'd40, 1'b1, 1'b0, 32'd0, 32'd40};
    tbl[13] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd40, 32'd44};
    tbl[14] = '{1'b1, 1'b1, 32'd24, 1'b1, 1'b0, 32'd0, 32'd24};
    tbl[15] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd24, 32'd28};
    tbl[16] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd24, 32'd32};
    tbl[17] = '{1'b1, 1'b1, 32'd8, 1'b0, 1'b0, 32'd0, 32'd8};
    tbl[18] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 32'd12};
    tbl[19] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 32'd16};
    tbl[20] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd12, 32'd20};
    tbl[21] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd12, 32'd20};
    tbl[22] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0};
    tbl[23] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0};
    tbl[24] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd4};
    tbl[25] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 32'd8};

    drive(1'b0, 1'b0, 32'd0, 1'b1);

    // Fixed cycle table: reset, streaming, stall, redirects, reset with two queued words.
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_im_pc", i), im_pc, tbl[i].eim);
      if (!tbl[i].rst) begin
        chk($sformatf("tbl%0d_rst_pc", i), out_pc, 32'd0);
        chk($sformatf("tbl%0d_rst_inst", i), out_inst, 32'd0);
      end else if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_inst", i), out_inst, mem_word(tbl[i].epc));
      end
      if (i == 2) chk("first_word", out_inst, 32'h0A0A2A0A);
      @(posedge clk);
      #1;
    end

    // Randomized run: presented words must follow the in-order PC stream.
    first  = 1'b0;
    exp_pc = 32'd8;
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom % 50) != 0;
      rv  = r && ((($urandom % 8) == 0) || (exp_pc >= 32'd1024));
      rpc = 32'($urandom_range(0, 255)) << 2;
      rdy = ($urandom % 4) != 0;
      drive(r, rv, rpc, rdy);
      @(negedge clk);
      ev = r && !rv && !first;
      chk($sformatf("rnd%0d_valid", c), {31'd0, out_valid}, {31'd0, ev});
      if (ev) begin
        chk($sformatf("rnd%0d_pc", c), out_pc, exp_pc);
        chk($sformatf("rnd%0d_inst", c), out_inst, mem_word(exp_pc));
      end
      if (!r) chk($sformatf("rnd%0d_rst_im_pc", c), im_pc, 32'd0);
      if (rv) chk($sformatf("rnd%0d_redir_im_pc", c), im_pc, rpc);
      if (!r) begin
        exp_pc = 32'd0;
        first  = 1'b1;
      end else begin
        first = 1'b0;
        if (rv) exp_pc = rpc;
        else if (ev && rdy) exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
    end

`ifdef IFETCH_BOUNDS_CHECK_EN
    // Misaligned redirect faults; a good redirect clears the fault and restarts the stream.
    drive(1'b1, 1'b1, 32'd62, 1'b1);
    @(negedge clk);
    chk("bnd_redir_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    chk("bnd_fault_set", {31'd0, fault}, 32'd1);
    chk("bnd_fault_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bnd_fault_sticky", {31'd0, fault}, 32'd1);
    chk("bnd_fault_valid2", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'd0, 1'b1);
    @(negedge clk);
    chk("bnd_fault_held", {31'd0, fault}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    chk("bnd_fault_clr", {31'd0, fault}, 32'd0);
    chk("bnd_resume_valid", {31'd0, out_valid}, 32'd1);
    chk("bnd_resume_pc", out_pc, 32'd0);
    chk("bnd_resume_inst", out_inst, 32'h0A0A2A0A);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
